// File: rtl/bc_stim_pkg.sv
// Shared types and constants for the barcode stimulus generator.
package bc_stim_pkg;

    localparam int MIN_PERIOD = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_LOW,
        ST_HIGH,
        ST_GAP
    } bc_state_e;

endpackage

// File: rtl/bc_id_fifo.sv
// Station-ID queue: show-ahead FIFO with wrap-bit pointers.
module bc_id_fifo #(
    parameter int ID_W       = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic            pop,
    input  logic [ID_W-1:0] din,
    output logic [ID_W-1:0] dout,
    output logic            full,
    output logic            empty
);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [ID_W-1:0] mem_q [FIFO_DEPTH];
    logic [AW:0]     wr_q;
    logic [AW:0]     rd_q;
    logic            do_wr;
    logic            do_rd;

    assign empty = (wr_q == rd_q);
    assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign do_rd = pop && !empty;
    // A pop frees the slot this cycle, so a push while full still lands.
    assign do_wr = push && (!full || do_rd);
    assign dout  = mem_q[rd_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (do_wr) begin
                mem_q[wr_q[AW-1:0]] <= din;
                wr_q                <= wr_q + (AW+1)'(1);
            end
            if (do_rd) begin
                rd_q <= rd_q + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/bc_stim_gen.sv
// Barcode line stimulus generator: frames queued station IDs as pulse-width cells.
// Define BC_PARITY_EN to append an odd-parity cell after the ID bits.
//   state | meaning
//   IDLE  | waiting for a queued ID
//   LOAD  | pop ID, latch period and gap
//   LOW   | low part of current bit cell
//   HIGH  | high part of current bit cell
//   GAP   | idle-high spacing after the frame
module bc_stim_gen
    import bc_stim_pkg::*;
#(
    parameter int ID_W       = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int PER_W      = 22
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PER_W-1:0] period,
    input  logic [PER_W-1:0] gap,
    input  logic             push,
    input  logic [ID_W-1:0]  push_id,
    output logic             full,
    output logic             empty,
    output logic             overflow,
    output logic             BC,
    output logic             busy,
    output logic             frame_done
);
`ifdef BC_PARITY_EN
    localparam int NB = ID_W + 2;
`else
    localparam int NB = ID_W + 1;
`endif
    localparam int BCW = $clog2(NB + 1);

    bc_state_e        state_q, state_d;
    logic [PER_W-1:0] per_q, per_d;
    logic [PER_W-1:0] gap_q, gap_d;
    logic [PER_W-1:0] cnt_q, cnt_d;
    logic [NB-1:0]    frame_q, frame_d;
    logic [BCW-1:0]   bits_q, bits_d;
    logic             bc_q, bc_d;
    logic             done_q, done_d;
    logic             ovf_q, ovf_d;
    logic             pop;
    logic [ID_W-1:0]  fifo_dout;
    logic [PER_W-1:0] per_clamped;
    logic [NB-1:0]    frame_new;

    function automatic logic [PER_W-1:0] low_len(input logic b, input logic [PER_W-1:0] p);
        return b ? (p >> 2) : (p - (p >> 2));
    endfunction

    bc_id_fifo #(
        .ID_W       (ID_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (push_id),
        .dout  (fifo_dout),
        .full  (full),
        .empty (empty)
    );

    assign per_clamped = (period < PER_W'(MIN_PERIOD)) ? PER_W'(MIN_PERIOD) : period;

    // Start bit leads at the MSB; cells are shifted out MSB first.
`ifdef BC_PARITY_EN
    assign frame_new = {1'b0, fifo_dout, ~^fifo_dout};
`else
    assign frame_new = {1'b0, fifo_dout};
`endif

    always_comb begin
        state_d = state_q;
        per_d   = per_q;
        gap_d   = gap_q;
        cnt_d   = cnt_q;
        frame_d = frame_q;
        bits_d  = bits_q;
        bc_d    = bc_q;
        done_d  = 1'b0;
        pop     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!empty) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                pop     = 1'b1;
                per_d   = per_clamped;
                gap_d   = gap;
                frame_d = frame_new;
                bits_d  = BCW'(NB);
                cnt_d   = low_len(1'b0, per_clamped) - PER_W'(1);
                bc_d    = 1'b0;
                state_d = ST_LOW;
            end
            ST_LOW: begin
                if (cnt_q == '0) begin
                    state_d = ST_HIGH;
                    bc_d    = 1'b1;
                    cnt_d   = per_q - low_len(frame_q[NB-1], per_q) - PER_W'(1);
                end else begin
                    cnt_d = cnt_q - PER_W'(1);
                end
            end
            ST_HIGH: begin
                if (cnt_q == '0) begin
                    if (bits_q > BCW'(1)) begin
                        frame_d = frame_q << 1;
                        bits_d  = bits_q - BCW'(1);
                        cnt_d   = low_len(frame_q[NB-2], per_q) - PER_W'(1);
                        bc_d    = 1'b0;
                        state_d = ST_LOW;
                    end else begin
                        done_d  = 1'b1;
                        cnt_d   = gap_q;
                        state_d = ST_GAP;
                    end
                end else begin
                    cnt_d = cnt_q - PER_W'(1);
                end
            end
            ST_GAP: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - PER_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
        ovf_d = ovf_q | (push & full & ~pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            per_q   <= '0;
            gap_q   <= '0;
            cnt_q   <= '0;
            frame_q <= '0;
            bits_q  <= '0;
            bc_q    <= 1'b1;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            per_q   <= per_d;
            gap_q   <= gap_d;
            cnt_q   <= cnt_d;
            frame_q <= frame_d;
            bits_q  <= bits_d;
            bc_q    <= bc_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
        end
    end

    assign BC         = bc_q;
    assign busy       = (state_q != ST_IDLE);
    assign frame_done = done_q;
    assign overflow   = ovf_q;

endmodule

// File: doc/bc_stim_gen.md
BC_STIM_GEN -- requirements
Module: bc_stim_gen

Interface
REQ-001 Parameter ID_W, default 8, station-ID bits per frame.
REQ-002 Parameter FIFO_DEPTH, default 4, queued IDs (power of 2, >=2).
REQ-003 Parameter PER_W, default 22, width of period and gap counters.
REQ-004 clk  in  1  sole clock, all state updates on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 period  in  PER_W  bit-cell length in clocks, sampled at frame start.
REQ-007 gap  in  PER_W  idle-high clocks inserted after each frame, sampled at frame start.
REQ-008 push  in  1  enqueue push_id this cycle.
REQ-009 push_id  in  ID_W  station ID to enqueue.
REQ-010 full  out  1  FIFO holds FIFO_DEPTH entries.
REQ-011 empty  out  1  FIFO holds zero entries.
REQ-012 overflow  out  1  sticky: a push was dropped while full.
REQ-013 BC  out  1  registered barcode line, idles high.
REQ-014 busy  out  1  high from frame start through end of gap.
REQ-015 frame_done  out  1  one-cycle pulse after last bit cell of a frame.

Function
REQ-016 Frame SHALL be a start bit (0), then ID_W ID bits MSB first.
REQ-017 Each bit cell SHALL be P clocks, P = latched period clamped to minimum MIN_PERIOD (8).
REQ-018 Bit 1: BC low for P>>2 clocks, then high for P-(P>>2); bit 0: low for P-(P>>2), then high for P>>2.
REQ-019 FSM states IDLE, LOAD, LOW, HIGH, GAP; IDLE->LOAD when !empty; LOAD->LOW (pops FIFO, latches P and gap); LOW->HIGH at low-count end; HIGH->LOW at next bit, else GAP; GAP->IDLE when gap count expires (gap=0 means one cycle in GAP).
REQ-020 From push into an empty FIFO with FSM idle, BC SHALL first go low exactly 2 clocks after the push edge.
REQ-021 frame_done SHALL pulse in the first GAP cycle; busy SHALL fall the cycle FSM re-enters IDLE.
REQ-022 Back-to-back queued IDs SHALL start with no extra cycles beyond gap plus the IDLE/LOAD pair.
REQ-023 Push while full and no pop same cycle SHALL be dropped and set overflow; push and pop in the same cycle while full SHALL both succeed.
REQ-024 FIFO pointers SHALL wrap modulo FIFO_DEPTH; full/empty derived from an extra pointer wrap bit.
REQ-025 Changes to period/gap mid-frame SHALL have no effect until the next LOAD.

Reset
REQ-026 While rst high: BC=1, busy=0, frame_done=0, overflow=0, empty=1, full=0, FSM=IDLE, counters zero.
REQ-027 Reset asserted mid-frame SHALL abort it: BC high on the next edge, queued IDs discarded, no frame_done.

Configuration
REQ-028 Macro BC_PARITY_EN defined: one odd-parity bit (over the ID bits) SHALL follow the last ID bit, same cell encoding; undefined: frame ends after ID bit 0.

Structure
REQ-029 Package bc_stim_pkg SHALL hold the state enum typedef and MIN_PERIOD constant.
REQ-030 FIFO SHALL be sub-module bc_id_fifo (parameters ID_W, FIFO_DEPTH; ports push, pop, din, dout, full, empty).

Verification
REQ-031 period=520, gap=0, push 0xA5 once -> BC low first 2 clocks after push; cells low 390/130/390/130... matching 0,1,0,1,0,0,1,0,1; frame_done once at clock 2+9*520.
REQ-032 period=4 -> cells measure 8 clocks (clamp), bit 1 low 2, bit 0 low 6.
REQ-033 Push 0x11,0x22,0x33,0x44 then 0x55 same burst (depth 4, idle) -> first pops, 0x55 accepted only if pop coincided, else overflow=1; decoded order preserved.
REQ-034 gap=1000, two IDs queued -> second frame's first low edge exactly 1000+3 clocks after first frame's last cell ends.
REQ-035 rst pulse at middle of bit 4 -> BC=1 next clock, empty=1, busy=0, no frame_done; new push afterwards frames normally.
REQ-036 With BC_PARITY_EN, push 0x07 -> 10 cells, final cell decodes 0 (three ones, odd parity); without it, 9 cells.
